// File: rtl/pkt_router.sv
// pkt_router: 4x4 packet interconnect between processing units.
// One input FIFO per source, one round-robin arbiter per destination.
// Sources have no backpressure: a packet reaching a full FIFO that is not
// popped in the same cycle is dropped and counted in a saturating counter.
// Delivered packets are driven from registered FIFO state, so there is no
// combinational path from any pu_tx input to any pu_rx output.
module pkt_router #(
  parameter int DEPTH = 4,
  parameter int PKTW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PKTW:0] pu_tx0,
  input  logic [PKTW:0] pu_tx1,
  input  logic [PKTW:0] pu_tx2,
  input  logic [PKTW:0] pu_tx3,
  output logic [PKTW:0] pu_rx0,
  output logic [PKTW:0] pu_rx1,
  output logic [PKTW:0] pu_rx2,
  output logic [PKTW:0] pu_rx3,
  output logic [7:0]    drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Per-source FIFO state.
  logic [PKTW:0]   r_mem  [4][DEPTH];
  logic [AW-1:0]   r_wptr [4];
  logic [AW-1:0]   r_rptr [4];
  logic [CW-1:0]   r_cnt  [4];
  // Per-destination round-robin pointers and the shared drop counter.
  logic [1:0]      r_rr   [4];
  logic [7:0]      r_drop_cnt;

  logic [PKTW:0]   w_tx       [4];
  logic [PKTW:0]   w_head     [4];
  logic [1:0]      w_head_dst [4];
  logic [3:0]      w_head_vld;
  logic [3:0]      w_gnt_vld;
  logic [1:0]      w_gnt_src  [4];
  logic [PKTW:0]   w_rx       [4];
  logic [3:0]      w_pop;
  logic [3:0]      w_push;
  logic [3:0]      w_drop;
  logic [2:0]      w_drop_n;
  logic [8:0]      w_drop_sum;

  assign w_tx[0] = pu_tx0;
  assign w_tx[1] = pu_tx1;
  assign w_tx[2] = pu_tx2;
  assign w_tx[3] = pu_tx3;

  // Expose each FIFO head: its word, whether it exists, and where it goes.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      w_head[s]     = r_mem[s][r_rptr[s]];
      w_head_vld[s] = (r_cnt[s] != '0);
      w_head_dst[s] = w_head[s][PKTW-1:PKTW-2];
    end
  end

  // Per-destination arbitration: search from rr[D] for the first head aimed at D.
  always_comb begin
    logic [1:0] v_cand;
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_gnt_vld = '0;
    w_pop     = '0;
    v_cand    = '0;
    for (int d = 0; d < 4; d++) begin
      w_gnt_src[d] = r_rr[d];
      w_rx[d]      = '0;
      for (int k = 0; k < 4; k++) begin
        v_cand = r_rr[d] + 2'(k);
        if (!w_gnt_vld[d] && w_head_vld[v_cand] && (w_head_dst[v_cand] == 2'(d))) begin
          w_gnt_vld[d] = 1'b1;
          w_gnt_src[d] = v_cand;
        end
      end
      // Outputs are forced idle while reset is held so queued packets never leak.
      if (w_gnt_vld[d] && !rst) begin
        w_pop[w_gnt_src[d]] = 1'b1;
        w_rx[d]             = w_head[w_gnt_src[d]];
      end
    end
  end

  // Push/drop decision per source and the saturating sum of this cycle's drops.
  always_comb begin
    logic v_full;
    w_push   = '0;
    w_drop   = '0;
    w_drop_n = '0;
    v_full   = 1'b0;
    for (int s = 0; s < 4; s++) begin
      v_full    = (r_cnt[s] == CW'(DEPTH));
      w_push[s] = w_tx[s][PKTW] && (!v_full || w_pop[s]);
      w_drop[s] = w_tx[s][PKTW] && v_full && !w_pop[s];
      w_drop_n  = w_drop_n + 3'(w_drop[s]);
    end
    w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_drop_n);
  end

  // FIFO pointers/occupancy, arbiter pointers and drop counter.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        r_wptr[s] <= '0;
        r_rptr[s] <= '0;
        r_cnt[s]  <= '0;
        r_rr[s]   <= '0;
      end
      r_drop_cnt <= '0;
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (w_push[s]) r_wptr[s] <= r_wptr[s] + AW'(1);
        if (w_pop[s])  r_rptr[s] <= r_rptr[s] + AW'(1);
        case ({w_push[s], w_pop[s]})
          2'b10:   r_cnt[s] <= r_cnt[s] + CW'(1);
          2'b01:   r_cnt[s] <= r_cnt[s] - CW'(1);
          default: r_cnt[s] <= r_cnt[s];
        endcase
      end
      for (int d = 0; d < 4; d++) begin
        if (w_gnt_vld[d]) r_rr[d] <= w_gnt_src[d] + 2'd1;
      end
      r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; emptiness comes from the
    // occupancy counts, so stale contents are never observable.
    for (int s = 0; s < 4; s++) begin
      if (!rst && w_push[s]) r_mem[s][r_wptr[s]] <= w_tx[s];
    end
  end

  assign pu_rx0   = w_rx[0];
  assign pu_rx1   = w_rx[1];
  assign pu_rx2   = w_rx[2];
  assign pu_rx3   = w_rx[3];
  assign drop_cnt = r_drop_cnt;

endmodule
